// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and default sizing for the multi-port register
//                file: clear-sequencer state encoding and LC-3 defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // LC-3 configuration: eight 16-bit general-purpose registers
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Bulk-clear sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_rdport
//  Description : One combinational read port: address mux over the array,
//                write-through bypass, zero for addresses beyond DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic [AW-1:0]    addr,
  input  logic             byp_en,
  input  logic [AW-1:0]    byp_addr,
  input  logic [WIDTH-1:0] byp_data,
  output logic [WIDTH-1:0] rd_data
);

  logic w_hit;

  // Select the addressed register; a hit only exists for in-range addresses,
  // so out-of-range reads stay zero and never pick up the bypass value.
  always_comb begin
    rd_data = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) begin
        rd_data = regs[i];
        w_hit   = 1'b1;
      end
    end
    if (w_hit && byp_en && (byp_addr == addr)) begin
      rd_data = byp_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised register file with two operand read ports, a
//                debug read port, per-register busy scoreboard and a
//                sequenced bulk-clear engine with busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  input  logic [AW-1:0]    rd_ext_addr,
  output logic [WIDTH-1:0] rd_ext_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [DEPTH-1:0] busy,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  clr_state_t       r_state;
  clr_state_t       w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic             w_clr_busy;
  logic             w_wr_act;
  logic             w_iss_act;
  logic [WIDTH-1:0] w_regs [DEPTH];
  logic [DEPTH-1:0] w_busy;

  // The sequencer owns the array while clearing; external strobes are masked
  assign w_clr_busy = (r_state == CLEAR);
  assign w_wr_act   = wr_en  & ~w_clr_busy;
  assign w_iss_act  = iss_en & ~w_clr_busy;

  // Clear sequencer state and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: the pointer holds on the last entry rather than wrapping
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_ptr == AW'(DEPTH - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign clr_busy = w_clr_busy;
  assign clr_done = (r_state == DONE);

  // Storage array: one register and one busy bit per entry, each with its
  // own decoded write, issue and clear enables.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic             r_q;
    logic [WIDTH-1:0] r_data;
    logic             w_wr_sel;
    logic             w_iss_sel;
    logic             w_clr_sel;

    assign w_wr_sel  = w_wr_act  && (wr_addr  == AW'(i));
    assign w_iss_sel = w_iss_act && (iss_addr == AW'(i));
    assign w_clr_sel = w_clr_busy && (r_ptr   == AW'(i));

    // Data register: clear beats write (they never coincide anyway)
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= '0;
      end else if (w_clr_sel) begin
        r_data <= '0;
      end else if (w_wr_sel) begin
        r_data <= wr_data;
      end
    end

    // Busy bit: issue beats a same-cycle write so the new producer is tracked
    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= 1'b0;
      end else if (w_clr_sel) begin
        r_q <= 1'b0;
      end else if (w_iss_sel) begin
        r_q <= 1'b1;
      end else if (w_wr_sel) begin
        r_q <= 1'b0;
      end
    end

    assign w_regs[i] = r_data;
    assign w_busy[i] = r_q;
  end

  assign busy = w_busy;

  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_a (
    .regs     (w_regs),
    .addr     (rd_a_addr),
    .byp_en   (w_wr_act),
    .byp_addr (wr_addr),
    .byp_data (wr_data),
    .rd_data  (rd_a_data)
  );

  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_b (
    .regs     (w_regs),
    .addr     (rd_b_addr),
    .byp_en   (w_wr_act),
    .byp_addr (wr_addr),
    .byp_data (wr_data),
    .rd_data  (rd_b_data)
  );

  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_ext (
    .regs     (w_regs),
    .addr     (rd_ext_addr),
    .byp_en   (w_wr_act),
    .byp_addr (wr_addr),
    .byp_data (wr_data),
    .rd_data  (rd_ext_data)
  );

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised general-purpose register file for the LC-3 datapath and its wider variants. It provides two operand read ports and one external debug read port, all combinational with write-through bypass. A per-register busy scoreboard supports pipelined issue, and a sequenced bulk-clear engine zeroes the array over DEPTH cycles with a busy/done handshake. It replaces the fixed 8×16 register file between the bus and the ALU operand inputs.

## Interface
- WIDTH, 16, register width in bits
- DEPTH, 8, number of registers, 2..64; need not be a power of two
- AW, $clog2(DEPTH), address width; derived, not overridden
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe from bus/writeback
- wr_addr  in  AW  write destination
- wr_data  in  WIDTH  write data (bus value)
- rd_a_addr, rd_b_addr  in  AW  operand read addresses
- rd_a_data, rd_b_data  out  WIDTH  operand read data, combinational
- rd_ext_addr  in  AW  debug viewing address
- rd_ext_data  out  WIDTH  debug read data, combinational
- iss_en  in  1  issue strobe: marks iss_addr as having a pending producer
- iss_addr  in  AW  register being issued to
- busy  out  DEPTH  scoreboard bit per register, registered
- clr_req  in  1  request bulk clear of array and scoreboard
- clr_busy  out  1  high while clear sequence runs
- clr_done  out  1  one-cycle pulse on clear completion

## Operation
- Reset: all registers 0, busy all 0, FSM IDLE, clr_busy 0, clr_done 0. rst overrides every other input in the same edge. rst during CLEAR aborts the sequence; there is no clr_done pulse.
- Write: at a clk edge with wr_en=1, clr_busy=0 and wr_addr<DEPTH, reg[wr_addr]←wr_data and busy[wr_addr]←0.
- Read: rd_x_data = reg[rd_x_addr]. Bypass: if wr_en=1, clr_busy=0 and wr_addr==rd_x_addr, then rd_x_data=wr_data in the same cycle. This applies to all three ports independently. An address ≥ DEPTH reads 0.
- Issue: at a clk edge with iss_en=1, clr_busy=0 and iss_addr<DEPTH, busy[iss_addr]←1. If issue and write target the same address in the same cycle, the register takes the data and busy ends at 1 (set wins).
- Out-of-range wr_addr or iss_addr is ignored with no side effect.
- Clear FSM states:
  - IDLE: clr_req=1 moves to CLEAR and sets ptr←0.
  - CLEAR: each cycle reg[ptr]←0, busy[ptr]←0, ptr←ptr+1. When ptr==DEPTH-1, go to DONE.
  - DONE: clr_done=1 for one cycle, then IDLE.
- clr_busy=1 exactly in CLEAR. While clr_busy=1, wr_en, iss_en and clr_req are ignored.
- clr_req held high through DONE starts a new clear from IDLE on the next cycle. There is no requeue of requests made during CLEAR.
- clr_req in the same cycle as an accepted wr_en or iss_en: both are accepted, because clr_busy is still 0 that cycle. The sequence later overwrites the results.
- Reads during CLEAR return the current, partially cleared contents with bypass disabled.

## Timing
- Read latency 0; bypass is combinational from wr_data to rd_x_data.
- Write, issue and busy update: visible in the cycle after the edge.
- Clear: clr_req sampled at edge 0. clr_busy is high from cycle 1 through cycle DEPTH. clr_done pulses in cycle DEPTH+1. The array reads all 0 from cycle DEPTH+1. Total occupancy is DEPTH+1 cycles before a new write is accepted.
- ptr width is AW and never wraps; the DEPTH-1 compare terminates it.

## Structure
- Shared package regfile_pkg holds:
  - FSM state encoding: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2
  - default WIDTH/DEPTH constants for the LC-3 configuration (16/8)
- Array: a generate loop of WIDTH-wide registers with per-register enables, decoded from the write port and the clear pointer.
- Sub-module regfile_rdport: address-indexed mux plus bypass compare, plus the out-of-range zero. It is instantiated three times.

## Test plan
- Reset then read all addresses: every rd_x_data=0 and busy=0. Write R3=16'hBEEF and read it via A/B/ext the next cycle: each returns 16'hBEEF.
- Bypass: wr_en=1, wr_addr=5, wr_data=16'h1234, with rd_a_addr=5 in the same cycle: rd_a_data=16'h1234 before the edge. rd_b_addr=4 returns the old R4.
- Scoreboard: iss R2 → busy=8'h04. Next, write R2 with 16'h00AA → busy=8'h00. Issue and write R6 in the same cycle → R6=data, busy[6]=1.
- Clear: fill R0..R7 with 16'hFFFF, then pulse clr_req. clr_busy is high for 8 cycles and clr_done pulses once at cycle 9. Writes during clr_busy are dropped and all registers read 0 afterward.
- rst asserted at cycle 4 of a clear: no clr_done, FSM IDLE, all registers 0 next cycle. A write then succeeds immediately.
- DEPTH=6, WIDTH=32: write to addr 7 is ignored and reads of addr 6/7 return 0. Clear takes 6 busy cycles.
